uart_tx_frame: RTL and testbench

Parametrised multi-byte UART transmitter and the next generation of the team's single-word serial sender.
- Latches a NUM_BYTES-wide word on a start handshake and serialises it as back-to-back 8-bit UART characters on one tx line.
- Adds configurable parity, stop-bit count, byte order, per-byte and per-frame completion pulses, and exact bit timing.
- Sits between the DES datapath output register and the board TX pin.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_bit_timer.sv | 22 ++
 rtl/uart_tx_frame.sv | 148 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity modes
// and elaboration-time timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Clock cycles per line bit; integer divide, caller guarantees result >= 2.
  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Line bits per character: start + 8 data + optional parity + stop bits.
  function automatic int char_bits(input int parity_mode, input int stop_bits);
    return 1 + 8 + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Start handshake, frame data and status/debug signals of the frame transmitter.
import uart_pkg::*;

// Handshake: a word is accepted on a rising clk edge where start=1 and ready=1;
// data_in is sampled only on that edge and ignored at all other times.
interface uart_tx_frame_if #(parameter int NUM_BYTES = 8);
  logic [8*NUM_BYTES-1:0] data_in;
  logic                   start;
  logic                   ready;
  logic                   busy;
  logic                   byte_done;
  logic                   frame_done;
  uart_state_t            state;

  modport master (
    output data_in, start,
    input  ready, busy, byte_done, frame_done, state
  );

  modport slave (
    input  data_in, start,
    output ready, busy, byte_done, frame_done, state
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit period counter: bit_end marks the last cycle of each CPB-cycle bit.
// Held at zero while clear is high so the first bit after clear is full length.
module uart_bit_timer #(
  parameter int CPB = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == LAST) && !clear;

  always_ff @(posedge clk) begin
    if (!reset || clear || bit_end) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: latches a NUM_BYTES word on start and sends it as
// back-to-back characters with optional parity and one or two stop bits.
import uart_pkg::*;

module uart_tx_frame #(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int BAUD_RATE      = 115200,
  parameter int NUM_BYTES      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1,
  parameter int MSB_BYTE_FIRST = 1
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_frame_if.slave  bus,
  output logic            tx
);
  localparam int CPB = cycles_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_t            state, state_n;
  logic [2:0]             bit_idx, bit_idx_n;
  logic [BW-1:0]          byte_idx, byte_idx_n;
  logic [8*NUM_BYTES-1:0] shift_buf, shift_buf_n;
  logic                   tx_n, byte_done_q, byte_done_n, frame_done_q, frame_done_n;
  logic [7:0]             cur_byte;
  logic                   par_bit, bit_end, idle;

  uart_bit_timer #(.CPB(CPB)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (idle),
    .bit_end (bit_end)
  );

  assign idle           = (state == ST_IDLE);
  assign bus.ready      = idle;
  assign bus.busy       = !idle;
  assign bus.byte_done  = byte_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.state      = state;

  // Character selection always reads the latched buffer, never live data_in.
  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (byte_idx == BW'(k)) begin
        cur_byte = (MSB_BYTE_FIRST != 0) ? shift_buf[8*(NUM_BYTES-1-k) +: 8]
                                         : shift_buf[8*k +: 8];
      end
    end
  end

  assign par_bit = (^cur_byte) ^ (PARITY_MODE == PARITY_ODD);

  always_comb begin
    state_n      = state;
    bit_idx_n    = bit_idx;
    byte_idx_n   = byte_idx;
    shift_buf_n  = shift_buf;
    byte_done_n  = 1'b0;
    frame_done_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          shift_buf_n = bus.data_in;
          byte_idx_n  = '0;
          bit_idx_n   = '0;
          state_n     = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_idx_n = '0;
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          bit_idx_n = '0;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            bit_idx_n   = '0;
            byte_done_n = 1'b1;
            if (byte_idx == LAST_BYTE) begin
              frame_done_n = 1'b1;
              state_n      = ST_IDLE;
            end else begin
              byte_idx_n = byte_idx + 1'b1;
              state_n    = ST_START;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // tx is registered from the next-state line value so it changes on the same
  // edge as the state, giving one cycle from acceptance to the start bit.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = cur_byte[bit_idx_n];
      ST_PARITY: tx_n = par_bit;
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bit_idx      <= '0;
      byte_idx     <= '0;
      shift_buf    <= '0;
      tx           <= 1'b1;
      byte_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      bit_idx      <= bit_idx_n;
      byte_idx     <= byte_idx_n;
      shift_buf    <= shift_buf_n;
      tx           <= tx_n;
      byte_done_q  <= byte_done_n;
      frame_done_q <= frame_done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations share one clock/reset; a line-level
// model expands each word into the expected per-cycle tx waveform.
`timescale 1ns/1ps
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = 10;

  // Per-instance configuration: A = defaults, B = even parity, C = odd parity,
  // D = two stop bits, LSB byte first.
  int nb_t[4]  = '{8, 1, 1, 2};
  int par_t[4] = '{0, 1, 2, 0};
  int stp_t[4] = '{1, 1, 1, 2};
  int msb_t[4] = '{1, 1, 1, 0};
  int len_t[4] = '{800, 110, 110, 220};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int           sel = 0;
  logic         start_drv = 1'b0;
  logic [127:0] data_drv = '0;
  logic         tog_en = 1'b0;

  uart_tx_frame_if #(.NUM_BYTES(8)) if_a();
  uart_tx_frame_if #(.NUM_BYTES(1)) if_b();
  uart_tx_frame_if #(.NUM_BYTES(1)) if_c();
  uart_tx_frame_if #(.NUM_BYTES(2)) if_d();
  logic tx_a, tx_b, tx_c, tx_d;

  assign if_a.start = start_drv && (sel == 0);
  assign if_b.start = start_drv && (sel == 1);
  assign if_c.start = start_drv && (sel == 2);
  assign if_d.start = start_drv && (sel == 3);
  assign if_a.data_in = data_drv[63:0];
  assign if_b.data_in = data_drv[7:0];
  assign if_c.data_in = data_drv[7:0];
  assign if_d.data_in = data_drv[15:0];

  uart_tx_frame #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .NUM_BYTES(8), .PARITY_MODE(0),
                  .STOP_BITS(1), .MSB_BYTE_FIRST(1))
    dut_a (.clk(clk), .reset(reset), .bus(if_a), .tx(tx_a));
  uart_tx_frame #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .NUM_BYTES(1), .PARITY_MODE(1),
                  .STOP_BITS(1), .MSB_BYTE_FIRST(1))
    dut_b (.clk(clk), .reset(reset), .bus(if_b), .tx(tx_b));
  uart_tx_frame #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .NUM_BYTES(1), .PARITY_MODE(2),
                  .STOP_BITS(1), .MSB_BYTE_FIRST(1))
    dut_c (.clk(clk), .reset(reset), .bus(if_c), .tx(tx_c));
  uart_tx_frame #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .NUM_BYTES(2), .PARITY_MODE(0),
                  .STOP_BITS(2), .MSB_BYTE_FIRST(0))
    dut_d (.clk(clk), .reset(reset), .bus(if_d), .tx(tx_d));

  logic tx_s, ready_s, busy_s, bd_s, fd_s;
  always_comb begin
    tx_s = tx_a; ready_s = if_a.ready; busy_s = if_a.busy;
    bd_s = if_a.byte_done; fd_s = if_a.frame_done;
    case (sel)
      1: begin tx_s = tx_b; ready_s = if_b.ready; busy_s = if_b.busy;
               bd_s = if_b.byte_done; fd_s = if_b.frame_done; end
      2: begin tx_s = tx_c; ready_s = if_c.ready; busy_s = if_c.busy;
               bd_s = if_c.byte_done; fd_s = if_c.frame_done; end
      3: begin tx_s = tx_d; ready_s = if_d.ready; busy_s = if_d.busy;
               bd_s = if_d.byte_done; fd_s = if_d.frame_done; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t sel=%0d: got %0h expected %0h", name, $time, sel, act, exp);
    end
  endtask

  function automatic void push_bit(input logic v);
    for (int i = 0; i < CPB; i++) exp_q.push_back(v);
  endfunction

  // Expand a word into the per-cycle line waveform from the framing rules.
  function automatic void build_expected(input int s, input logic [127:0] d);
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < nb_t[s]; k++) begin
      b = (msb_t[s] != 0) ? d[8*(nb_t[s]-1-k) +: 8] : d[8*k +: 8];
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(b[i]);
      if (par_t[s] != 0) push_bit((^b) ^ (par_t[s] == 2));
      for (int j = 0; j < stp_t[s]; j++) push_bit(1'b1);
    end
  endfunction

  function automatic int char_len(input int s);
    return (9 + ((par_t[s] != 0) ? 1 : 0) + stp_t[s]) * CPB;
  endfunction

  task automatic check_line(input string name);
    logic [0:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: tx still framing, expected queue empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {7'd0, tx_s}, {7'd0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves the bench at a negedge.
  task automatic wait_ready(input int limit);
    int n = 0;
    while (!ready_s && n < limit) begin @(negedge clk); n++; end
    if (!ready_s) begin
      checks++; errors++;
      $display("FAIL wait_ready: ready=%0b after %0d cycles, required 1", ready_s, n);
    end
  endtask

  task automatic run_frame(input int s, input logic [127:0] d, input int flen);
    int cl;
    logic exp_bd;
    sel = s;
    cl  = char_len(s);
    wait_ready(2000);
    data_drv  = d;
    start_drv = 1'b1;
    build_expected(s, d);
    @(posedge clk);
    for (int c = 1; c <= flen; c++) begin
      @(negedge clk);
      check_line("tx_bit");
      exp_bd = (c > 1) && ((c - 1) % cl == 0);
      check("status", {4'd0, ready_s, busy_s, bd_s, fd_s}, {4'd0, 1'b0, 1'b1, exp_bd, 1'b0});
      // A start and new data while busy must not disturb the frame.
      if (c == 1) start_drv = 1'b0;
      if (c == 3) begin start_drv = 1'b1; data_drv = ~d; end
      if (c == 4) start_drv = 1'b0;
    end
    @(negedge clk);
    check("frame_end", {3'd0, tx_s, ready_s, busy_s, bd_s, fd_s}, 8'b0001_1011);
  endtask

  task automatic toggler();
    while (tog_en) begin
      repeat (7) @(posedge clk);
      #2;
      if (tog_en) data_drv[7:0] = 8'($urandom);
    end
  endtask

  typedef struct {
    int           s;
    logic [127:0] data;
    int           flen;
  } vec_t;
  vec_t vecs[$];

  initial begin
    logic [7:0] cap;

    // Reset held with start high: outputs idle, nothing accepted.
    sel = 0; reset = 1'b0; start_drv = 1'b1; data_drv = 128'h0123456789ABCDEF;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("reset_hold", {3'd0, tx_s, ready_s, busy_s, bd_s, fd_s}, 8'b0001_1000);
    end
    reset = 1'b1;
    // start is already high: acceptance happens on the very next edge.
    run_frame(0, 128'h0123456789ABCDEF, 800);

    // Vector table: directed framing cases then random words on every config.
    vecs.push_back('{0, 128'h0123456789ABCDEF, 800});
    vecs.push_back('{1, 128'h07, 110});
    vecs.push_back('{2, 128'h07, 110});
    vecs.push_back('{3, 128'hA55A, 220});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{i % 4, {$urandom, $urandom, $urandom, $urandom}, len_t[i % 4]});
    for (int v = 0; v < vecs.size(); v++) run_frame(vecs[v].s, vecs[v].data, vecs[v].flen);

    // Back-to-back frames with start held high and data_in churning.
    sel = 1;
    wait_ready(2000);
    tog_en = 1'b1;
    fork toggler(); join_none
    start_drv = 1'b1;
    for (int f = 0; f < 3; f++) begin
      cap = data_drv[7:0];
      build_expected(1, {120'd0, cap});
      @(posedge clk);
      for (int c = 1; c <= 110; c++) begin
        @(negedge clk);
        check_line("b2b_tx");
        check("b2b_status", {4'd0, ready_s, busy_s, bd_s, fd_s}, 8'b0000_0100);
      end
      @(negedge clk);
      check("b2b_end", {3'd0, tx_s, ready_s, busy_s, bd_s, fd_s}, 8'b0001_1011);
    end
    start_drv = 1'b0;
    tog_en = 1'b0;

    // Reset during data bit 3 of character 2 aborts without done pulses.
    sel = 0;
    wait_ready(2000);
    data_drv = {$urandom, $urandom, $urandom, $urandom};
    start_drv = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 245; c++) begin
      @(negedge clk);
      if (c == 1) start_drv = 1'b0;
    end
    check("pre_abort_busy", {7'd0, busy_s}, 8'd1);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort", {3'd0, tx_s, ready_s, busy_s, bd_s, fd_s}, 8'b0001_1000);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("post_abort", {3'd0, tx_s, ready_s, busy_s, bd_s, fd_s}, 8'b0001_1000);
    end
    run_frame(0, {$urandom, $urandom, $urandom, $urandom}, 800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
